// File: rtl/sdf_stage_ctrl.sv
// Radix-2 single-delay-feedback FFT stage: delay line, stage counter, half-frame muxing,
// twiddle addressing and one combinational butterfly (a + b*w, a - b*w).
module sdf_stage_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned TW_STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_r,
    input  logic [WIDTH-1:0]      in_i,
    input  logic                  flush,
    output logic [ADDR_W-1:0]     tw_addr,
    input  logic [WIDTH/2-1:0]    tw_r,
    input  logic [WIDTH/2-1:0]    tw_i,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic [WIDTH-1:0]      out_r,
    output logic [WIDTH-1:0]      out_i
);
    localparam int unsigned CW = $clog2(2 * DEPTH);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned HW = WIDTH / 2;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [CW-1:0] CntLastP0  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CntFirstP1 = CW'(DEPTH);
    localparam logic [CW-1:0] CntLast    = CW'(2 * DEPTH - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             primed_q, primed_d;
    logic             p0_used_q, p0_used_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sop_q, out_sop_d;
    logic [WIDTH-1:0] out_r_q, out_r_d;
    logic [WIDTH-1:0] out_i_q, out_i_d;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] mem_i [DEPTH];

    logic             phase1;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] head_r, head_i;
    logic             in_step, fl_step;

    // Every step advances the line by one slot, so the low counter bits are the head index.
    assign phase1 = cnt_q[CW-1];
    assign idx    = cnt_q[IW-1:0];
    assign head_r = mem_r[idx];
    assign head_i = mem_i[idx];

    assign tw_addr = phase1 ? ADDR_W'(idx) * ADDR_W'(TW_STRIDE) : '0;

    logic signed [PW-1:0] b_r_x, b_i_x, w_r_x, w_i_x, m_r, m_i;
    logic [WIDTH-1:0]     s_r, s_i, sum_r, sum_i, dif_r, dif_i;

    assign b_r_x = PW'($signed(in_r));
    assign b_i_x = PW'($signed(in_i));
    assign w_r_x = PW'($signed(tw_r));
    assign w_i_x = PW'($signed(tw_i));
    assign m_r   = b_r_x * w_r_x - b_i_x * w_i_x;
    assign m_i   = b_r_x * w_i_x + b_i_x * w_r_x;
    // Twiddles are Q1.(HW-1): drop the fractional bits, keep WIDTH bits, no rounding.
    assign s_r   = WIDTH'(m_r >>> (HW - 1));
    assign s_i   = WIDTH'(m_i >>> (HW - 1));
    assign sum_r = head_r + s_r;
    assign sum_i = head_i + s_i;
    assign dif_r = head_r - s_r;
    assign dif_i = head_i - s_i;

    assign in_step = in_valid;
    assign fl_step = flush & ~in_valid & ~phase1 & primed_q & ~p0_used_q;

    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        p0_used_d   = p0_used_q;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        if (in_step) begin
            cnt_d = cnt_q + CW'(1);
            if (!phase1) begin
                p0_used_d = 1'b1;
                if (primed_q) begin
                    out_valid_d = 1'b1;
                    out_r_d     = head_r;
                    out_i_d     = head_i;
                end
                if (cnt_q == CntLastP0) begin
                    p0_used_d = 1'b0;
                end
            end else begin
                out_valid_d = 1'b1;
                out_sop_d   = (cnt_q == CntFirstP1);
                out_r_d     = sum_r;
                out_i_d     = sum_i;
                if (cnt_q == CntLast) begin
                    primed_d = 1'b1;
                end
            end
        end else if (fl_step) begin
            out_valid_d = 1'b1;
            out_r_d     = head_r;
            out_i_d     = head_i;
            // A completed drain skips phase1 and leaves the stage unprimed.
            if (cnt_q == CntLastP0) begin
                cnt_d    = '0;
                primed_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            p0_used_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            p0_used_q   <= p0_used_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_step) begin
            mem_r[idx] <= phase1 ? dif_r : in_r;
            mem_i[idx] <= phase1 ? dif_i : in_i;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;

endmodule
